// File: rtl/reset_pkg.sv
// reset_pkg: shared FSM state type and default parameters for the reset sequencer
package reset_pkg;
    typedef enum logic [1:0] {RESET, HOLD, RELEASE, IDLE} state_e;
    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_STRETCH_CYCLES = 16;
    localparam int DEF_STAGGER_CYCLES = 4;
endpackage

// File: rtl/rst_sync.sv
// rst_sync: async-assert / sync-deassert reset synchroniser
//   clk     : clock
//   rst_n_i : raw asynchronous active-low reset
//   rst_n_o : synchronised active-low reset, released SYNC_STAGES edges after rst_n_i rises
module rst_sync import reset_pkg::*; #(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n_i,
    output logic rst_n_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_n_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretched, staggered per-channel reset release with software reset requests
//   clk            : clock
//   hardware_rst_n : asynchronous active-low reset; forces every channel into reset
//   software_rst   : single-cycle request, honoured only when idle and mask is non-zero
//   sw_rst_mask    : channels targeted by software_rst
//   internal_rst   : registered active-high per-channel resets
//   sw_rst_ack     : one-cycle pulse when a software request is accepted
//   rst_done       : every channel released and sequencer idle
module reset_sequencer import reset_pkg::*; #(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES
) (
    input  logic              clk,
    input  logic              hardware_rst_n,
    input  logic              software_rst,
    input  logic [NUM_CH-1:0] sw_rst_mask,
    output logic [NUM_CH-1:0] internal_rst,
    output logic              sw_rst_ack,
    output logic              rst_done
);
    localparam int MAX_CNT = STRETCH_CYCLES > STAGGER_CYCLES ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0] target_q, target_d, rst_q, rst_d, pending, lowest;
    logic              ack_q, ack_d, done_q, done_d, sync_n, release_now, accept;
    rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n_i (hardware_rst_n),
        .rst_n_o (sync_n)
    );
    always_ff @(posedge clk or negedge hardware_rst_n) begin
        if (!hardware_rst_n) begin
            state_q  <= RESET;
            cnt_q    <= '0;
            target_q <= '1;
            rst_q    <= '1;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            rst_q    <= rst_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
        end
    end
    always_comb begin
        // targets still held; the lowest one is the next to be released
        pending     = target_q & rst_q;
        lowest      = pending & (~pending + 1'b1);
        // the channel release coincides with the edge that ends a HOLD or stagger interval
        release_now = (state_q == HOLD    && cnt_q == CW'(STRETCH_CYCLES - 1)) ||
                      (state_q == RELEASE && cnt_q == CW'(STAGGER_CYCLES - 1));
        accept      = state_q == IDLE && software_rst && |sw_rst_mask;
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        rst_d       = rst_q;
        ack_d       = accept;
        done_d      = state_q == IDLE && !accept;
        case (state_q)
            RESET: state_d = sync_n ? HOLD : RESET;
            HOLD, RELEASE: begin
                cnt_d = release_now ? '0 : cnt_q + 1'b1;
                if (release_now) begin
                    rst_d   = rst_q & ~lowest;
                    state_d = (pending & ~lowest) == '0 ? IDLE : RELEASE;
                end
            end
            IDLE: if (accept) begin
                state_d  = HOLD;
                cnt_d    = '0;
                target_d = sw_rst_mask;
                rst_d    = rst_q | sw_rst_mask;
            end
            default: state_d = RESET;
        endcase
    end
    assign internal_rst = rst_q;
    assign sw_rst_ack   = ack_q;
    assign rst_done     = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, hand corner sequences and randomized checks against a timeline model
module tb_reset_sequencer;
    localparam int NUM_CH  = 4;
    localparam int SYNC    = 2;
    localparam int STRETCH = 8;
    localparam int STAGGER = 4;
    localparam int INF     = 32'h3fff_ffff;

    logic              clk            = 1'b0;
    logic              hardware_rst_n = 1'b0;
    logic              software_rst   = 1'b0;
    logic [NUM_CH-1:0] sw_rst_mask    = '0;
    logic [NUM_CH-1:0] internal_rst;
    logic              sw_rst_ack;
    logic              rst_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .STRETCH_CYCLES(STRETCH), .STAGGER_CYCLES(STAGGER)
    ) dut (
        .clk            (clk),
        .hardware_rst_n (hardware_rst_n),
        .software_rst   (software_rst),
        .sw_rst_mask    (sw_rst_mask),
        .internal_rst   (internal_rst),
        .sw_rst_ack     (sw_rst_ack),
        .rst_done       (rst_done)
    );

    // Timeline model: each channel has the edge number at which it is released;
    // a channel is in reset before that edge. The sequence ends at the last release edge.
    int t = 0;
    int rel [NUM_CH] = '{default: INF};
    int last = INF;
    bit armed = 1'b1;
    bit acc;
    int rank;
    logic m_ack = 1'b0;
    logic m_done = 1'b0;

    always @(posedge clk or negedge hardware_rst_n) begin
        if (!hardware_rst_n) begin
            rel    = '{default: INF};
            last   = INF;
            armed  = 1'b1;
            m_ack  = 1'b0;
            m_done = 1'b0;
        end else begin
            t++;
            if (armed) begin
                armed = 1'b0;
                for (int k = 0; k < NUM_CH; k++) rel[k] = t + SYNC + STRETCH + k * STAGGER;
                last = rel[NUM_CH-1];
            end
            acc    = software_rst && sw_rst_mask != 0 && t > last;
            m_ack  = acc;
            m_done = t > last && !acc;
            if (acc) begin
                rank = 0;
                for (int k = 0; k < NUM_CH; k++)
                    if (sw_rst_mask[k]) begin
                        rel[k] = t + STRETCH + rank * STAGGER;
                        last   = rel[k];
                        rank++;
                    end
            end
        end
    end

    function automatic logic [NUM_CH-1:0] m_rst();
        for (int k = 0; k < NUM_CH; k++) m_rst[k] = !hardware_rst_n || t < rel[k];
    endfunction

    task automatic check(input string name, input logic [NUM_CH-1:0] er, input logic ea, input logic ed);
        n_cmp++;
        if ({internal_rst, sw_rst_ack, rst_done} !== {er, ea, ed}) begin
            n_bad++;
            $display("FAIL %s: got rst=%b ack=%b done=%b, want rst=%b ack=%b done=%b",
                     name, internal_rst, sw_rst_ack, rst_done, er, ea, ed);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic              hw;
        logic              sw;
        logic [NUM_CH-1:0] mask;
        int                n;
        logic [NUM_CH-1:0] e_rst;
        logic              e_ack;
        logic              e_done;
    } vec_t;

    vec_t vecs [21];

    initial begin
        // edge numbers in notes count from the first edge with hardware_rst_n high (edge 0)
        vecs[0]  = '{1'b0, 1'b0, 4'h0, 1, 4'hF, 1'b0, 1'b0}; // in reset
        vecs[1]  = '{1'b1, 1'b0, 4'h0, 1, 4'hF, 1'b0, 1'b0}; // edge 0
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 9, 4'hF, 1'b0, 1'b0}; // edge 9
        vecs[3]  = '{1'b1, 1'b0, 4'h0, 1, 4'hE, 1'b0, 1'b0}; // edge 10
        vecs[4]  = '{1'b1, 1'b0, 4'h0, 3, 4'hE, 1'b0, 1'b0}; // edge 13
        vecs[5]  = '{1'b1, 1'b0, 4'h0, 1, 4'hC, 1'b0, 1'b0}; // edge 14
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 4, 4'h8, 1'b0, 1'b0}; // edge 18
        vecs[7]  = '{1'b1, 1'b0, 4'h0, 4, 4'h0, 1'b0, 1'b0}; // edge 22
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 1, 4'h0, 1'b0, 1'b1}; // edge 23
        vecs[9]  = '{1'b1, 1'b1, 4'hA, 1, 4'hA, 1'b1, 1'b0}; // edge 24 sw accept
        vecs[10] = '{1'b1, 1'b0, 4'h0, 7, 4'hA, 1'b0, 1'b0}; // edge 31
        vecs[11] = '{1'b1, 1'b0, 4'h0, 1, 4'h8, 1'b0, 1'b0}; // edge 32 bit1 clears
        vecs[12] = '{1'b1, 1'b0, 4'h0, 3, 4'h8, 1'b0, 1'b0}; // edge 35
        vecs[13] = '{1'b1, 1'b0, 4'h0, 1, 4'h0, 1'b0, 1'b0}; // edge 36 bit3 clears
        vecs[14] = '{1'b1, 1'b0, 4'h0, 1, 4'h0, 1'b0, 1'b1}; // edge 37
        vecs[15] = '{1'b1, 1'b1, 4'h0, 1, 4'h0, 1'b0, 1'b1}; // zero mask ignored
        vecs[16] = '{1'b1, 1'b1, 4'h1, 1, 4'h1, 1'b1, 1'b0}; // edge 39 accept
        vecs[17] = '{1'b1, 1'b1, 4'h4, 1, 4'h1, 1'b0, 1'b0}; // request in HOLD ignored
        vecs[18] = '{1'b1, 1'b0, 4'h0, 6, 4'h1, 1'b0, 1'b0}; // edge 46
        vecs[19] = '{1'b1, 1'b0, 4'h0, 1, 4'h0, 1'b0, 1'b0}; // edge 47
        vecs[20] = '{1'b1, 1'b0, 4'h0, 1, 4'h0, 1'b0, 1'b1}; // edge 48

        #1;
        for (int i = 0; i < 21; i++) begin
            hardware_rst_n = vecs[i].hw;
            software_rst   = vecs[i].sw;
            sw_rst_mask    = vecs[i].mask;
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].e_rst, vecs[i].e_ack, vecs[i].e_done);
        end
        software_rst = 1'b0;
        sw_rst_mask  = '0;

        // abort mid-RELEASE after bit0 has cleared
        hardware_rst_n = 1'b0;
        step(2);
        check("hw_hold_low", 4'hF, 1'b0, 1'b0);
        hardware_rst_n = 1'b1;
        step(12);
        check("rel_bit0", 4'hE, 1'b0, 1'b0);
        #2 hardware_rst_n = 1'b0;
        #1 check("abort_async", 4'hF, 1'b0, 1'b0);
        hardware_rst_n = 1'b1;
        step(10);
        check("restart_hold", 4'hF, 1'b0, 1'b0);
        step(1);
        check("restart_bit0", 4'hE, 1'b0, 1'b0);
        step(12);
        check("restart_last", 4'h0, 1'b0, 1'b0);
        step(1);
        check("restart_done", 4'h0, 1'b0, 1'b1);

        // sub-cycle glitch on hardware_rst_n between edges
        @(posedge clk);
        #3 hardware_rst_n = 1'b0;
        #1 check("glitch_async", 4'hF, 1'b0, 1'b0);
        #1 hardware_rst_n = 1'b1;
        step(10);
        check("glitch_hold", 4'hF, 1'b0, 1'b0);
        step(1);
        check("glitch_bit0", 4'hE, 1'b0, 1'b0);
        step(12);
        check("glitch_last", 4'h0, 1'b0, 1'b0);
        step(1);
        check("glitch_done", 4'h0, 1'b0, 1'b1);

        // randomized traffic against the timeline model
        for (int c = 0; c < 1500; c++) begin
            hardware_rst_n = $urandom_range(0, 199) != 0;
            software_rst   = $urandom_range(0, 3) == 0;
            sw_rst_mask    = NUM_CH'($urandom_range(0, 15));
            step(1);
            check($sformatf("rand%0d", c), m_rst(), m_ack, m_done);
            if ($urandom_range(0, 249) == 0) begin
                #3 hardware_rst_n = 1'b0;
                #1 check($sformatf("rand_glitch%0d", c), m_rst(), m_ack, m_done);
                #1 hardware_rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
